// File: rtl/ed_comp_bank_pkg.sv
// Shared definitions for the edge-comparator bank: mode encoding and threshold width.
// Latency: n/a (package). Backpressure: n/a.
// Threshold width leaves room for a full signed product plus one carry bit.
package ed_pkg;

    localparam logic MODE_LEVEL = 1'b0;
    localparam logic MODE_PULSE = 1'b1;

    function automatic int THR_BITS(input int in_bits);
        return 2 * in_bits + 1;
    endfunction

endpackage

// File: rtl/ed_comp_chan.sv
// One comparator channel: config registers, stage-1 thr = x + dx*outer_count, stage-2 compare/pulse.
// Latency: 2 cycles from inputs to out; config used 1 edge after its write edge.
// Backpressure: none, accepts a sample every cycle.
module ed_comp_chan
    import ed_pkg::*;
#(
    parameter int IN_BITS = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [IN_BITS-1:0] wr_x,
    input  logic [IN_BITS-1:0] wr_dx,
    input  logic               wr_mode,
    input  logic               wr_ch_en,
    input  logic [IN_BITS-1:0] outer_count,
    input  logic [IN_BITS-1:0] count_d,
    input  logic               enable_d,
    input  logic               keep_prev,
    output logic               out
);

    localparam int THR = THR_BITS(IN_BITS);

    logic [IN_BITS-1:0]    x_q;
    logic [IN_BITS-1:0]    dx_q;
    logic                  mode_q;
    logic                  en_q;
    logic signed [THR-1:0] thr_q;
    logic                  mode_s1;
    logic                  en_s1;
    logic                  prev_q;

    logic signed [THR-1:0] x_ext;
    logic signed [THR-1:0] dx_ext;
    logic signed [THR-1:0] oc_ext;
    logic signed [THR-1:0] cnt_ext;
    logic signed [THR-1:0] thr_nxt;
    logic                  cmp;

    // Everything is widened before the multiply so the product is exact.
    always_comb begin
        x_ext   = {{(THR-IN_BITS){x_q[IN_BITS-1]}}, x_q};
        dx_ext  = {{(THR-IN_BITS){dx_q[IN_BITS-1]}}, dx_q};
        oc_ext  = {{(THR-IN_BITS){outer_count[IN_BITS-1]}}, outer_count};
        cnt_ext = {{(THR-IN_BITS){count_d[IN_BITS-1]}}, count_d};
        thr_nxt = x_ext + dx_ext * oc_ext;
        cmp     = enable_d & en_s1 & (cnt_ext >= thr_q);
    end

    // mode/en travel with thr so an in-flight sample never mixes old and new config.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_q     <= '0;
            dx_q    <= '0;
            mode_q  <= MODE_LEVEL;
            en_q    <= 1'b0;
            thr_q   <= '0;
            mode_s1 <= MODE_LEVEL;
            en_s1   <= 1'b0;
            prev_q  <= 1'b0;
            out     <= 1'b0;
        end else begin
            if (wr_en) begin
                x_q    <= wr_x;
                dx_q   <= wr_dx;
                mode_q <= wr_mode;
                en_q   <= wr_ch_en;
            end
            thr_q   <= thr_nxt;
            mode_s1 <= mode_q;
            en_s1   <= en_q;
            prev_q  <= cmp;
            out     <= (mode_s1 == MODE_PULSE) ? (cmp & ~(prev_q & keep_prev)) : cmp;
        end
    end

endmodule

// File: rtl/ed_comp_bank.sv
// N_CH-channel signed edge-comparator bank; ED_COMP_STICKY_EN adds sticky fired status.
// Latency: 2 cycles count/outer_count/enable to out, throughput 1/cycle.
// Backpressure: none, free-running pipeline with no stalls.
module ed_comp_bank
    import ed_pkg::*;
#(
    parameter int IN_BITS = 32,
    parameter int N_CH    = 8,
    parameter int CH_BITS = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [IN_BITS-1:0] count,
    input  logic [IN_BITS-1:0] outer_count,
    input  logic               wr_en,
    input  logic [CH_BITS-1:0] wr_ch,
    input  logic [IN_BITS-1:0] wr_x,
    input  logic [IN_BITS-1:0] wr_dx,
    input  logic               wr_mode,
    input  logic               wr_ch_en,
    input  logic               fired_clr,
    output logic [N_CH-1:0]    out,
    output logic [N_CH-1:0]    fired
);

    logic [IN_BITS-1:0] count_d;
    logic [IN_BITS-1:0] oc_d;
    logic [IN_BITS-1:0] oc_dd;
    logic               enable_d;
    logic               keep_prev;
    logic [N_CH-1:0]    out_vec;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_d  <= '0;
            oc_d     <= '0;
            oc_dd    <= '0;
            enable_d <= 1'b0;
        end else begin
            count_d  <= count;
            oc_d     <= outer_count;
            oc_dd    <= oc_d;
            enable_d <= enable;
        end
    end

    // A fresh outer index or a disabled cycle re-arms every pulse channel.
    assign keep_prev = enable_d & (oc_d == oc_dd);

    for (genvar g = 0; g < N_CH; g++) begin : g_chan
        ed_comp_chan #(.IN_BITS(IN_BITS)) u_chan (
            .clk         (clk),
            .reset       (reset),
            .wr_en       (wr_en && (wr_ch == CH_BITS'(g))),
            .wr_x        (wr_x),
            .wr_dx       (wr_dx),
            .wr_mode     (wr_mode),
            .wr_ch_en    (wr_ch_en),
            .outer_count (outer_count),
            .count_d     (count_d),
            .enable_d    (enable_d),
            .keep_prev   (keep_prev),
            .out         (out_vec[g])
        );
    end

    assign out = out_vec;

`ifdef ED_COMP_STICKY_EN
    logic [N_CH-1:0] fired_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            fired_q <= '0;
        end else begin
            fired_q <= (fired_clr ? '0 : fired_q) | out_vec;
        end
    end

    assign fired = fired_q;
`else
    logic unused_fired_clr;

    assign unused_fired_clr = fired_clr;
    assign fired            = '0;
`endif

endmodule

// File: tb/tb_ed_comp_bank.sv
// Directed self-checking bench for ed_comp_bank (IN_BITS=32, N_CH=6, CH_BITS=3).
module tb_ed_comp_bank;

    localparam int IB = 32;
    localparam int NC = 6;
    localparam int CB = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [IB-1:0] count;
    logic [IB-1:0] outer_count;
    logic          wr_en;
    logic [CB-1:0] wr_ch;
    logic [IB-1:0] wr_x;
    logic [IB-1:0] wr_dx;
    logic          wr_mode;
    logic          wr_ch_en;
    logic          fired_clr;
    logic [NC-1:0] out;
    logic [NC-1:0] fired;

    int total = 0;
    int bad   = 0;

`ifdef ED_COMP_STICKY_EN
    localparam logic STICKY = 1'b1;
`else
    localparam logic STICKY = 1'b0;
`endif

    ed_comp_bank #(.IN_BITS(IB), .N_CH(NC), .CH_BITS(CB)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .count       (count),
        .outer_count (outer_count),
        .wr_en       (wr_en),
        .wr_ch       (wr_ch),
        .wr_x        (wr_x),
        .wr_dx       (wr_dx),
        .wr_mode     (wr_mode),
        .wr_ch_en    (wr_ch_en),
        .fired_clr   (fired_clr),
        .out         (out),
        .fired       (fired)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        tick();
        tick();
    endtask

    task automatic wr(input logic [CB-1:0] ch, input logic [IB-1:0] x, input logic [IB-1:0] dx,
                      input logic m, input logic e);
        wr_ch    = ch;
        wr_x     = x;
        wr_dx    = dx;
        wr_mode  = m;
        wr_ch_en = e;
        wr_en    = 1'b1;
        tick();
        wr_en    = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int prevc;
        int c;

        reset       = 1'b1;
        enable      = 1'b0;
        count       = '0;
        outer_count = '0;
        wr_en       = 1'b0;
        wr_ch       = '0;
        wr_x        = '0;
        wr_dx       = '0;
        wr_mode     = 1'b0;
        wr_ch_en    = 1'b0;
        fired_clr   = 1'b0;
        tick();
        tick();
        check("reset_out", 32'(out), 32'h0);
        check("reset_fired", 32'(fired), 32'h0);
        reset = 1'b0;

        // LEVEL: thr = 100 + 10*3 = 130
        enable      = 1'b1;
        outer_count = 32'd3;
        wr(3'd2, 32'd100, 32'd10, 1'b0, 1'b1);
        settle();
        check("lvl_idle", 32'(out), 32'h0);
        prevc = 0;
        for (int i = 0; i < 12; i++) begin
            c     = (i > 10) ? 135 : 125 + i;
            count = 32'(c);
            tick();
            check("lvl_sweep", 32'(out), (prevc >= 130) ? 32'h4 : 32'h0);
            prevc = c;
        end

        // PULSE on ch0, thr = -5, count 0
        count       = '0;
        outer_count = '0;
        wr(3'd2, 32'd0, 32'd0, 1'b0, 1'b0);
        wr(3'd0, 32'hFFFF_FFFB, 32'd0, 1'b1, 1'b1);
        tick();
        check("pulse_pre", 32'(out), 32'h0);
        tick();
        check("pulse_on", 32'(out), 32'h1);
        tick();
        check("pulse_off1", 32'(out), 32'h0);
        tick();
        check("pulse_off2", 32'(out), 32'h0);
        outer_count = 32'd1;
        tick();
        check("rearm_pre", 32'(out), 32'h0);
        tick();
        check("rearm_on", 32'(out), 32'h1);
        tick();
        check("rearm_off", 32'(out), 32'h0);

        // Extreme values: no wrap, exact signed product
        wr(3'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 1'b1);
        outer_count = 32'd2;
        count       = 32'h7FFF_FFFF;
        settle();
        check("ext_big_max", 32'(out), 32'h0);
        count = 32'h8000_0000;
        settle();
        check("ext_big_min", 32'(out), 32'h0);
        wr(3'd0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
        outer_count = 32'h8000_0000;
        count       = 32'h7FFF_FFFF;
        settle();
        check("ext_negneg", 32'(out), 32'h0);
        outer_count = 32'd1;
        settle();
        check("ext_thr_lo", 32'(out), 32'h1);
        count = 32'h7FFF_FFFE;
        settle();
        check("ext_thr_eq", 32'(out), 32'h1);
        count = 32'h7FFF_FFFD;
        settle();
        check("ext_thr_below", 32'(out), 32'h0);
        wr(3'd0, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1);
        outer_count = 32'h8000_0000;
        count       = 32'h8000_0000;
        settle();
        check("ext_very_neg", 32'(out), 32'h1);

        // Out-of-range channel writes change nothing
        wr(3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        wr(3'd7, 32'hFFFF_FF9C, 32'd0, 1'b0, 1'b1);
        wr(3'd6, 32'hFFFF_FF9C, 32'd0, 1'b0, 1'b1);
        count       = '0;
        outer_count = '0;
        settle();
        check("bad_ch_ignored", 32'(out), 32'h0);

        // Global enable
        wr(3'd1, 32'hFFFF_FF9C, 32'd0, 1'b0, 1'b1);
        settle();
        check("en_on", 32'(out), 32'h2);
        enable = 1'b0;
        tick();
        check("en_off_lat1", 32'(out), 32'h2);
        tick();
        check("en_off_lat2", 32'(out), 32'h0);

        // Reset mid-run
        enable = 1'b1;
        settle();
        check("rst_pre", 32'(out), 32'h2);
        reset = 1'b1;
        tick();
        check("rst_out", 32'(out), 32'h0);
        check("rst_fired", 32'(fired), 32'h0);
        reset = 1'b0;
        settle();
        check("rst_cfg_clear", 32'(out), 32'h0);

        // Sticky status on ch1
        wr(3'd1, 32'hFFFF_FFFB, 32'd0, 1'b1, 1'b1);
        tick();
        check("stk_pre", 32'(out), 32'h0);
        tick();
        check("stk_pulse", 32'(out), 32'h2);
        tick();
        check("stk_pulse_end", 32'(out), 32'h0);
        check("stk_set", 32'(fired[1]), 32'(STICKY));
        settle();
        check("stk_hold", 32'(fired[1]), 32'(STICKY));
        outer_count = 32'd1;
        settle();
        check("stk_pulse2", 32'(out), 32'h2);
        fired_clr = 1'b1;
        tick();
        check("stk_set_wins", 32'(fired[1]), 32'(STICKY));
        tick();
        check("stk_clr", 32'(fired[1]), 32'h0);
        check("stk_clr_out", 32'(out), 32'h0);
        fired_clr = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
